// File: rtl/uart_reg_sched.sv
// uart_reg_sched: owns the UART IP register port, drains RX bytes and feeds THR from a TX FIFO.
// The post-reset configuration sequence is built only when `UART_REG_SCHED_INIT_EN is defined.
module uart_reg_sched #(
  parameter logic [15:0] DIVISOR  = 16'h000F,
  parameter int unsigned TX_DEPTH = 16
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data_i,
  input  logic       tx_data_wr_i,
  output logic       tx_full_o,
  output logic       tx_drop_o,
  output logic [7:0] rx_data_o,
  output logic       rx_data_wr_o,
  output logic       rx_err_o,
  output logic       init_done_o,
  output logic       ip_tx_en_o,
  output logic [2:0] ip_waddr_o,
  output logic [7:0] ip_wdata_o,
  output logic       ip_rx_en_o,
  output logic [2:0] ip_raddr_o,
  input  logic [7:0] ip_rdata_i
);

  localparam int unsigned PW = $clog2(TX_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(TX_DEPTH);

  localparam logic [2:0] A_RBR = 3'd0;
  localparam logic [2:0] A_THR = 3'd0;
  localparam logic [2:0] A_DLL = 3'd0;
  localparam logic [2:0] A_DLM = 3'd1;
  localparam logic [2:0] A_FCR = 3'd2;
  localparam logic [2:0] A_LCR = 3'd3;
  localparam logic [2:0] A_LSR = 3'd5;

  // INITn: config write | POLL: read LSR | PCHK: act on LSR | RD/RCAP: read RBR, capture | WR: write THR
  typedef enum logic [3:0] {
`ifdef UART_REG_SCHED_INIT_EN
    S_INIT0,
    S_INIT1,
    S_INIT2,
    S_INIT3,
    S_INIT4,
`endif
    S_POLL,
    S_PCHK,
    S_RD,
    S_RCAP,
    S_WR
  } state_e;

`ifdef UART_REG_SCHED_INIT_EN
  localparam state_e S_RESET = S_INIT0;
`else
  localparam state_e S_RESET = S_POLL;
`endif

  state_e        state_q, state_d;
  logic          run_q;
  logic          push, pop, lsr_err, rx_cap;
  logic          fifo_full, fifo_empty;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [TX_DEPTH];
  logic          tx_full_q, tx_drop_q;
  logic [7:0]    rx_data_q;
  logic          rx_wr_q, rx_err_q;
`ifdef UART_REG_SCHED_INIT_EN
  logic          init_fin;
  logic          init_done_q;
`endif

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);

  // The port decode is combinational on state, so run_q masks it while rst_n is low and
  // holds the FSM for one cycle after release so the reset state's action is not skipped.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q   <= 1'b0;
      state_q <= S_RESET;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ip_tx_en_o = 1'b0;
    ip_waddr_o = '0;
    ip_wdata_o = '0;
    ip_rx_en_o = 1'b0;
    ip_raddr_o = '0;
    pop        = 1'b0;
    lsr_err    = 1'b0;
    rx_cap     = 1'b0;
`ifdef UART_REG_SCHED_INIT_EN
    init_fin   = 1'b0;
`endif
    if (run_q) begin
      case (state_q)
`ifdef UART_REG_SCHED_INIT_EN
        S_INIT0: begin
          ip_tx_en_o = 1'b1;
          ip_waddr_o = A_LCR;
          ip_wdata_o = 8'h83;
          state_d    = S_INIT1;
        end
        S_INIT1: begin
          ip_tx_en_o = 1'b1;
          ip_waddr_o = A_DLL;
          ip_wdata_o = DIVISOR[7:0];
          state_d    = S_INIT2;
        end
        S_INIT2: begin
          ip_tx_en_o = 1'b1;
          ip_waddr_o = A_DLM;
          ip_wdata_o = DIVISOR[15:8];
          state_d    = S_INIT3;
        end
        S_INIT3: begin
          ip_tx_en_o = 1'b1;
          ip_waddr_o = A_LCR;
          ip_wdata_o = 8'h03;
          state_d    = S_INIT4;
        end
        S_INIT4: begin
          ip_tx_en_o = 1'b1;
          ip_waddr_o = A_FCR;
          ip_wdata_o = 8'h07;
          init_fin   = 1'b1;
          state_d    = S_POLL;
        end
`endif
        S_POLL: begin
          ip_rx_en_o = 1'b1;
          ip_raddr_o = A_LSR;
          state_d    = S_PCHK;
        end
        S_PCHK: begin
          lsr_err = |ip_rdata_i[4:1];
          // Receive wins over transmit so the IP receiver cannot overrun.
          if (ip_rdata_i[0]) begin
            state_d = S_RD;
          end else if (ip_rdata_i[5] && !fifo_empty) begin
            state_d = S_WR;
          end else begin
            state_d = S_POLL;
          end
        end
        S_RD: begin
          ip_rx_en_o = 1'b1;
          ip_raddr_o = A_RBR;
          state_d    = S_RCAP;
        end
        S_RCAP: begin
          rx_cap  = 1'b1;
          state_d = S_POLL;
        end
        S_WR: begin
          ip_tx_en_o = 1'b1;
          ip_waddr_o = A_THR;
          ip_wdata_o = mem_q[rd_ptr_q];
          pop        = 1'b1;
          state_d    = S_POLL;
        end
        default: state_d = S_RESET;
      endcase
    end
  end

  // A pop in the same cycle frees the slot, so a write while full is still taken.
  assign push = tx_data_wr_i & (~fifo_full | pop);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tx_full_q <= 1'b0;
      tx_drop_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= count_d;
      tx_full_q <= (count_d == FULL_CNT);
      tx_drop_q <= tx_data_wr_i & ~push;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data_i;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q <= '0;
      rx_wr_q   <= 1'b0;
      rx_err_q  <= 1'b0;
    end else begin
      if (rx_cap) rx_data_q <= ip_rdata_i;
      rx_wr_q  <= rx_cap;
      rx_err_q <= lsr_err;
    end
  end

`ifdef UART_REG_SCHED_INIT_EN
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done_q <= 1'b0;
    end else if (init_fin) begin
      init_done_q <= 1'b1;
    end
  end
  assign init_done_o = init_done_q;
`else
  // Without the sequence the divisor has no consumer; the IP power-on settings apply.
  logic unused_divisor;
  assign unused_divisor = ^DIVISOR;
  assign init_done_o    = 1'b1;
`endif

  assign tx_full_o    = tx_full_q;
  assign tx_drop_o    = tx_drop_q;
  assign rx_data_o    = rx_data_q;
  assign rx_data_wr_o = rx_wr_q;
  assign rx_err_o     = rx_err_q;

endmodule
